// File: rtl/uart2wb.sv
// uart2wb: UART-to-Wishbone master bridge (target side of a UART-tunnelled Wishbone link).
// Receives a request frame on uart_rx, runs one Wishbone classic read or write cycle, then
// sends a response frame on uart_tx.
//   Request : cmd (bit0 = we), A address bytes, [D data bytes, 1 sel byte] -- all LSB first
//   Response: read -> D bytes of read data; write -> 1 status byte (01 = ack, 00 = timeout)
// Ports:
//   clock, reset (async, active low)
//   uart_rx / uart_tx            : 8N1 serial, idle high
//   wb_adr, wb_datwr, wb_datrd,
//   wb_we, wb_stb, wb_cyc, wb_sel,
//   wb_ack                       : Wishbone classic master
//   busy                         : high whenever the bridge is not idle
module uart2wb #(
  parameter int unsigned addr_width         = 32,
  parameter int unsigned data_width         = 32,
  parameter int unsigned strobe_width       = data_width / 8,
  parameter int unsigned clk_per_bit        = 217,
  parameter int unsigned ack_timeout        = 255,
  parameter int unsigned frame_timeout_bits = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  output logic [addr_width-1:0]   wb_adr,
  output logic [data_width-1:0]   wb_datwr,
  input  logic [data_width-1:0]   wb_datrd,
  output logic                    wb_we,
  output logic                    wb_stb,
  output logic                    wb_cyc,
  output logic [strobe_width-1:0] wb_sel,
  input  logic                    wb_ack,
  output logic                    busy
);

  localparam int unsigned ABytes   = (addr_width + 7) / 8;
  localparam int unsigned DBytes   = (data_width + 7) / 8;
  localparam int unsigned AW8      = ABytes * 8;
  localparam int unsigned DW8      = DBytes * 8;
  localparam int unsigned CntW     = $clog2(clk_per_bit + 1);
  localparam int unsigned FrameMax = 2 + ABytes + DBytes;
  localparam int unsigned FrmW     = $clog2(FrameMax + 1);
  localparam int unsigned GapMax   = frame_timeout_bits * clk_per_bit;
  localparam int unsigned GapW     = $clog2(GapMax + 1);
  localparam int unsigned AckW     = $clog2(ack_timeout + 1);
  localparam int unsigned TxByteW  = $clog2(DBytes + 1);

  localparam logic [CntW-1:0]    BitLast  = CntW'(clk_per_bit - 1);
  localparam logic [CntW-1:0]    HalfLast = CntW'((clk_per_bit / 2 > 0) ? clk_per_bit / 2 - 1 : 0);
  localparam logic [FrmW-1:0]    AdrEnd   = FrmW'(1 + ABytes);
  localparam logic [FrmW-1:0]    DatEnd   = FrmW'(1 + ABytes + DBytes);
  localparam logic [FrmW-1:0]    LenRd    = FrmW'(1 + ABytes);
  localparam logic [FrmW-1:0]    LenWr    = FrmW'(2 + ABytes + DBytes);
  localparam logic [GapW-1:0]    GapLim   = GapW'(GapMax);
  localparam logic [AckW-1:0]    AckLast  = AckW'(ack_timeout - 1);
  localparam logic [TxByteW-1:0] LastRd   = TxByteW'(DBytes - 1);
  localparam logic [TxByteW-1:0] LastWr   = TxByteW'(0);

  // ---------------------------------------------------------------- UART receiver
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid, rx_ferr, rx_idle;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          // Start bit re-checked mid-bit; a high line here was a glitch.
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_state_d = RxIdle;
          rx_valid   = rx_sync_q;
          rx_ferr    = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign rx_idle = (rx_state_q == RxIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------------------------------------------------------- bridge FSM
  typedef enum logic [1:0] {StIdle, StRxFrame, StWbReq, StTxResp} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [FrmW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [AW8-1:0]      adr_q, adr_d;
  logic [DW8-1:0]      dat_q, dat_d;
  logic [AW8+7:0]      adr_cat;
  logic [DW8+7:0]      dat_cat;
  logic [strobe_width-1:0] sel_q, sel_d;
  logic                stb_q, stb_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [AckW-1:0]     ack_cnt_q, ack_cnt_d;
  logic [DW8-1:0]      resp_q, resp_d;
  logic                tx_q, tx_d;
  logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]          tx_bit_q, tx_bit_d;
  logic [TxByteW-1:0]  tx_byte_q, tx_byte_d;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    byte_cnt_d = byte_cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    gap_d      = gap_q;
    ack_cnt_d  = ack_cnt_q;
    resp_d     = resp_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    // Bytes arrive LSB first: shift each new byte in from the top.
    adr_cat    = {rx_shift_q, adr_q};
    dat_cat    = {rx_shift_q, dat_q};

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          we_d       = rx_shift_q[0];
          byte_cnt_d = FrmW'(1);
          gap_d      = '0;
          state_d    = StRxFrame;
        end
      end
      StRxFrame: begin
        if (rx_ferr) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          gap_d      = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q < AdrEnd) begin
            adr_d = adr_cat[AW8+7:8];
          end else if (byte_cnt_q < DatEnd) begin
            dat_d = dat_cat[DW8+7:8];
          end
          if (byte_cnt_d == (we_q ? LenWr : LenRd)) begin
            // For writes the byte just received is the sel byte.
            sel_d     = we_q ? rx_shift_q[strobe_width-1:0] : '1;
            stb_d     = 1'b1;
            ack_cnt_d = '0;
            state_d   = StWbReq;
          end
        end else if (!rx_idle) begin
          gap_d = '0;
        end else if (gap_q == GapLim) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StWbReq: begin
        if (wb_ack || (ack_cnt_q == AckLast)) begin
          stb_d  = 1'b0;
          resp_d = '0;
          if (wb_ack) begin
            if (we_q) resp_d[7:0] = 8'h01;
            else      resp_d[data_width-1:0] = wb_datrd;
          end
          tx_d      = 1'b0;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          tx_byte_d = '0;
          state_d   = StTxResp;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      StTxResp: begin
        // tx_bit_q: 0 = start, 1..8 = data, 9 = stop.
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == (we_q ? LastWr : LastRd)) begin
              tx_d    = 1'b1;
              state_d = StIdle;
            end else begin
              tx_byte_d = tx_byte_q + 1'b1;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
              resp_d    = resp_q >> 8;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : resp_q[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      byte_cnt_q <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      stb_q      <= 1'b0;
      gap_q      <= '0;
      ack_cnt_q  <= '0;
      resp_q     <= '0;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      byte_cnt_q <= byte_cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      stb_q      <= stb_d;
      gap_q      <= gap_d;
      ack_cnt_q  <= ack_cnt_d;
      resp_q     <= resp_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign uart_tx  = tx_q;
  assign wb_adr   = adr_q[addr_width-1:0];
  assign wb_datwr = dat_q[data_width-1:0];
  assign wb_we    = we_q;
  assign wb_stb   = stb_q;
  assign wb_cyc   = stb_q;
  assign wb_sel   = sel_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart2wb.sv
// Directed self-checking bench for uart2wb (clk_per_bit = 4, ack_timeout = 8).
module tb_uart2wb;
  localparam int Cpb = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_rx;
  logic        uart_tx;
  logic [31:0] wb_adr;
  logic [31:0] wb_datwr;
  logic [31:0] wb_datrd;
  logic        wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0;
  logic        busy;

  logic [31:0] rd_val;
  int          ack_delay;
  int          n_run = 0;
  int          n_fail = 0;

  assign wb_datrd = rd_val;

  uart2wb #(
    .addr_width(32), .data_width(32), .strobe_width(4), .clk_per_bit(Cpb),
    .ack_timeout(8), .frame_timeout_bits(20)
  ) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd), .wb_we(wb_we),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel), .wb_ack(wb_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  // Slave model: acks ack_delay cycles after stb first seen (-1 = never).
  int          cur = 0, stb_cycles = 0, cyc_pulses = 0, unstable = 0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic [3:0]  cap_sel = '0;
  logic        cap_we = 1'b0;

  always @(negedge clock) begin
    if (wb_stb) begin
      if (cur == 0) begin
        cyc_pulses <= cyc_pulses + 1;
        cap_adr    <= wb_adr;
        cap_dat    <= wb_datwr;
        cap_sel    <= wb_sel;
        cap_we     <= wb_we;
      end else if (wb_adr !== cap_adr || wb_datwr !== cap_dat || wb_sel !== cap_sel ||
                   wb_we !== cap_we) begin
        unstable <= unstable + 1;
      end
      if (wb_cyc !== 1'b1) unstable <= unstable + 1;
      wb_ack     <= (ack_delay >= 0 && cur == ack_delay);
      cur        <= cur + 1;
      stb_cycles <= stb_cycles + 1;
    end else begin
      wb_ack <= 1'b0;
      cur    <= 0;
    end
  end

  // UART monitor on uart_tx: samples each bit near its centre.
  logic [7:0] tx_bytes [0:31];
  int         tx_count = 0, tx_bad_stop = 0;

  always begin : tx_mon
    logic [7:0] b;
    @(negedge clock);
    if (uart_tx === 1'b0) begin
      repeat (2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (Cpb) @(negedge clock);
        b[i] = uart_tx;
      end
      repeat (Cpb) @(negedge clock);
      if (uart_tx !== 1'b1) tx_bad_stop++;
      if (tx_count < 32) tx_bytes[tx_count] = b;
      tx_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Cpb) @(negedge clock);
    end
    uart_rx = stop;
    repeat (Cpb) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  logic [7:0] frm [$];

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i], 1'b1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int k = 0;
    while (tx_count < target && k < budget) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clock);
      k++;
    end
  endtask

  int p0, s0, t0;

  task automatic snap();
    p0 = cyc_pulses;
    s0 = stb_cycles;
    t0 = tx_count;
  endtask

  initial begin
    reset     = 1'b0;
    uart_rx   = 1'b1;
    ack_delay = 0;
    rd_val    = 32'hDEADBEEF;
    repeat (3) @(negedge clock);
    chk("rst_tx", uart_tx, 1);
    chk("rst_stb", wb_stb, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_datwr", wb_datwr, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 1: read at 0x10, ack after 2 cycles
    ack_delay = 2;
    snap();
    frm = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx(t0 + 4, 400);
    wait_idle(100);
    chk("t1_txcount", tx_count - t0, 4);
    chk("t1_pulses", cyc_pulses - p0, 1);
    chk("t1_stbcyc", stb_cycles - s0, 3);
    chk("t1_adr", cap_adr, 32'h10);
    chk("t1_we", cap_we, 0);
    chk("t1_sel", cap_sel, 4'hF);
    chk("t1_b0", tx_bytes[t0], 8'hEF);
    chk("t1_b1", tx_bytes[t0+1], 8'hBE);
    chk("t1_b2", tx_bytes[t0+2], 8'hAD);
    chk("t1_b3", tx_bytes[t0+3], 8'hDE);
    chk("t1_busy", busy, 0);

    // 2: write, ack in the first stb cycle
    ack_delay = 0;
    snap();
    frm = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h03};
    send_frame();
    wait_tx(t0 + 1, 200);
    wait_idle(100);
    chk("t2_txcount", tx_count - t0, 1);
    chk("t2_pulses", cyc_pulses - p0, 1);
    chk("t2_stbcyc", stb_cycles - s0, 1);
    chk("t2_adr", cap_adr, 32'h4);
    chk("t2_dat", cap_dat, 32'h12345678);
    chk("t2_sel", cap_sel, 4'h3);
    chk("t2_we", cap_we, 1);
    chk("t2_resp", tx_bytes[t0], 8'h01);

    // 3: write with no ack -> timeout after 8 cycles
    ack_delay = -1;
    snap();
    send_frame();
    wait_tx(t0 + 1, 200);
    wait_idle(100);
    chk("t3_txcount", tx_count - t0, 1);
    chk("t3_stbcyc", stb_cycles - s0, 8);
    chk("t3_stb_low", wb_stb, 0);
    chk("t3_resp", tx_bytes[t0], 8'h00);

    // 4: partial frame, long idle gap, then a read at 0x20
    ack_delay = 1;
    rd_val    = 32'hCAFEF00D;
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (25 * Cpb) @(negedge clock);
    chk("t4_gap_idle", busy, 0);
    frm = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx(t0 + 4, 400);
    wait_idle(100);
    chk("t4_pulses", cyc_pulses - p0, 1);
    chk("t4_adr", cap_adr, 32'h20);
    chk("t4_we", cap_we, 0);
    chk("t4_b0", tx_bytes[t0], 8'h0D);
    chk("t4_b3", tx_bytes[t0+3], 8'hCA);

    // 5: framing error mid-frame, then a good read at 0x30
    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (10) @(negedge clock);
    chk("t5_ferr_busy", busy, 0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (100) @(negedge clock);
    chk("t5_no_cycle", cyc_pulses - p0, 0);
    chk("t5_no_tx", tx_count - t0, 0);
    chk("t5_tx_idle", uart_tx, 1);
    wait_idle(200);
    snap();
    frm = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_tx(t0 + 4, 400);
    wait_idle(100);
    chk("t5_pulses", cyc_pulses - p0, 1);
    chk("t5_adr", cap_adr, 32'h30);
    chk("t5_b1", tx_bytes[t0+1], 8'hF0);

    // 6: reset asserted during the bus cycle
    ack_delay = -1;
    frm = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    send_frame();
    begin
      int k = 0;
      while (wb_stb !== 1'b1 && k < 40) begin
        @(negedge clock);
        k++;
      end
    end
    chk("t6_stb_up", wb_stb, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_stb", wb_stb, 0);
    chk("t6_cyc", wb_cyc, 0);
    chk("t6_tx", uart_tx, 1);
    chk("t6_busy", busy, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_busy_after", busy, 0);
    ack_delay = 0;
    snap();
    frm = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F};
    send_frame();
    wait_tx(t0 + 1, 200);
    wait_idle(100);
    chk("t6_pulses", cyc_pulses - p0, 1);
    chk("t6_adr", cap_adr, 32'h8);
    chk("t6_dat", cap_dat, 32'hDDCCBBAA);
    chk("t6_sel", cap_sel, 4'hF);
    chk("t6_resp", tx_bytes[t0], 8'h01);

    chk("bus_stable", unstable, 0);
    chk("tx_stop_bits", tx_bad_stop, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
